// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback and drives all datapath selects.
// Latency: 3-5 cycles per instruction; outputs are registered Moore, except PCWrite/IRWrite in FETCH, which follow mem_ready.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold while mem_ready=0. Build option ILLEGAL_OP_TRAP_EN adds the TRAP state and the Trap port.
module mips_multicycle_control #(
   parameter int RA_REG = 31
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OP,
   input  logic [5:0] Funct,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCondEQ,
   output logic       PCWriteCondNE,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       Jal,
   output logic [4:0] JalReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [2:0] ALUOp,
`ifdef ILLEGAL_OP_TRAP_EN
   output logic       Trap,
`endif
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_JR        = 4'd10,
      S_IMM_EXEC  = 4'd11,
      S_IMM_WB    = 4'd12,
      S_TRAP      = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   // Registered control word; 'fetch' marks FETCH so PCWrite/IRWrite can be qualified by mem_ready.
   typedef struct packed {
      logic       pc_write;
      logic       fetch;
      logic       cond_eq;
      logic       cond_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       jal;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
`ifdef ILLEGAL_OP_TRAP_EN
      logic       trap;
`endif
   } ctrl_t;

   // Moore control word for a state; op only selects among variants of IMM_EXEC, BRANCH and JUMP.
   function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.fetch     = 1'b1;
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEM_READ: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_EXECUTE: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 3'b111;
         end
         S_ALU_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_IMM_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            case (op)
               OP_ANDI: c.alu_op = 3'b010;
               OP_ORI:  c.alu_op = 3'b011;
               OP_LUI:  c.alu_op = 3'b101;
               default: c.alu_op = 3'b000;
            endcase
         end
         S_IMM_WB: begin
            c.reg_write = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 3'b001;
            c.pc_source = 2'b01;
            c.cond_eq   = (op == OP_BEQ);
            c.cond_ne   = (op == OP_BNE);
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
            if (op == OP_JAL) begin
               c.reg_write = 1'b1;
               c.jal       = 1'b1;
            end
         end
         S_JR: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b11;
         end
`ifdef ILLEGAL_OP_TRAP_EN
         S_TRAP: begin
            c.trap = 1'b1;
         end
`endif
         default: ;
      endcase
      return c;
   endfunction

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;

   // Next-state selection and the control word that the next state will present.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:     if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (OP)
               OP_RTYPE:               state_d = (Funct == FN_JR) ? S_JR : S_EXECUTE;
               OP_LW, OP_SW:           state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE:         state_d = S_BRANCH;
               OP_J, OP_JAL:           state_d = S_JUMP;
               OP_ADDI, OP_ANDI,
               OP_ORI, OP_LUI:         state_d = S_IMM_EXEC;
`ifdef ILLEGAL_OP_TRAP_EN
               default:                state_d = S_TRAP;
`else
               default:                state_d = S_FETCH;
`endif
            endcase
         end
         S_MEM_ADDR:  state_d = (OP == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECUTE:   state_d = S_ALU_WB;
         S_ALU_WB:    state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         S_JR:        state_d = S_FETCH;
         S_IMM_EXEC:  state_d = S_IMM_WB;
         S_IMM_WB:    state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
         S_TRAP:      state_d = S_TRAP;
`endif
         default:     state_d = S_FETCH;
      endcase
      ctrl_d = ctrl_for(state_d, OP);
   end

   // State and control-word registers; reset lands in FETCH with its outputs already valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         ctrl_q  <= ctrl_for(S_FETCH, 6'h00);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign PCWrite       = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready);
   assign IRWrite       = ctrl_q.fetch & mem_ready;
   assign PCWriteCondEQ = ctrl_q.cond_eq;
   assign PCWriteCondNE = ctrl_q.cond_ne;
   assign IorD          = ctrl_q.iord;
   assign MemRead       = ctrl_q.mem_read;
   assign MemWrite      = ctrl_q.mem_write;
   assign MemtoReg      = ctrl_q.mem_to_reg;
   assign RegDst        = ctrl_q.reg_dst;
   assign RegWrite      = ctrl_q.reg_write;
   assign Jal           = ctrl_q.jal;
   assign JalReg        = 5'(RA_REG);
   assign ALUSrcA       = ctrl_q.alu_src_a;
   assign ALUSrcB       = ctrl_q.alu_src_b;
   assign PCSource      = ctrl_q.pc_source;
   assign ALUOp         = ctrl_q.alu_op;
   assign State         = state_q;
`ifdef ILLEGAL_OP_TRAP_EN
   assign Trap          = ctrl_q.trap;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instruction-level reference model plus directed literal checks.
// The model plans each instruction as a list of states and derives outputs from a per-state table.
// Works in both builds; ILLEGAL_OP_TRAP_EN enables the trap checks and the Trap port.
module tb_mips_multicycle_control;

   typedef int iq_t[$];

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mem_ready = 1'b1;
   logic [5:0] OP = 6'h00;
   logic [5:0] Funct = 6'h00;
   logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, Jal, ALUSrcA;
   logic [4:0] JalReg;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUOp;
   logic [3:0] State;
   logic       trap_obs;

`ifdef ILLEGAL_OP_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
   logic Trap;
   assign trap_obs = Trap;
`else
   localparam bit TRAP_EN = 1'b0;
   assign trap_obs = 1'b0;
`endif

   always #5 clk = ~clk;

   mips_multicycle_control #(.RA_REG(31)) dut (
      .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .Jal(Jal),
      .JalReg(JalReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALUOp(ALUOp),
`ifdef ILLEGAL_OP_TRAP_EN
      .Trap(Trap),
`endif
      .State(State)
   );

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   bit rw_seen = 1'b0;

   // ---------------- reference model ----------------
   int  m_state = 0;
   iq_t m_seq;
   bit  m_valid = 1'b0;

   // States an instruction walks through after DECODE.
   function automatic iq_t plan(input logic [5:0] op, input logic [5:0] fn);
      iq_t q;
      case (op)
         6'h00: if (fn == 6'h08) q.push_back(10); else begin q.push_back(6); q.push_back(7); end
         6'h23: begin q.push_back(2); q.push_back(3); q.push_back(4); end
         6'h2B: begin q.push_back(2); q.push_back(5); end
         6'h04, 6'h05: q.push_back(8);
         6'h02, 6'h03: q.push_back(9);
         6'h08, 6'h0C, 6'h0D, 6'h0F: begin q.push_back(11); q.push_back(12); end
         default: if (TRAP_EN) q.push_back(13);
      endcase
      return q;
   endfunction

   // Full expected output vector for a state, opcode and current mem_ready.
   function automatic logic [28:0] exp_out(input int st, input logic [5:0] op, input logic mr);
      logic       pcw, eq, ne, iord, mrd, mwr, irw, m2r, rdst, rw, jal, srca, trp;
      logic [1:0] srcb, pcs;
      logic [2:0] aop;
      logic [3:0] s4;
      {pcw, eq, ne, iord, mrd, mwr, irw, m2r, rdst, rw, jal, srca, trp} = '0;
      srcb = 2'b00; pcs = 2'b00; aop = 3'b000;
      s4 = st[3:0];
      case (st)
         0:  begin pcw = mr; irw = mr; mrd = 1'b1; srcb = 2'b01; end
         1:  srcb = 2'b11;
         2:  begin srca = 1'b1; srcb = 2'b10; end
         3:  begin mrd = 1'b1; iord = 1'b1; end
         4:  begin rw = 1'b1; m2r = 1'b1; end
         5:  begin mwr = 1'b1; iord = 1'b1; end
         6:  begin srca = 1'b1; aop = 3'b111; end
         7:  begin rw = 1'b1; rdst = 1'b1; end
         8:  begin srca = 1'b1; aop = 3'b001; pcs = 2'b01; eq = (op == 6'h04); ne = (op == 6'h05); end
         9:  begin pcw = 1'b1; pcs = 2'b10; rw = (op == 6'h03); jal = (op == 6'h03); end
         10: begin pcw = 1'b1; pcs = 2'b11; end
         11: begin
                srca = 1'b1; srcb = 2'b10;
                aop = (op == 6'h0C) ? 3'b010 : (op == 6'h0D) ? 3'b011 : (op == 6'h0F) ? 3'b101 : 3'b000;
             end
         12: rw = 1'b1;
         13: trp = 1'b1;
         default: ;
      endcase
      return {s4, pcw, eq, ne, iord, mrd, mwr, irw, m2r, rdst, rw, jal, 5'd31, srca, srcb, pcs, aop, trp};
   endfunction

   // Model advances on the same edge as the DUT.
   always @(posedge clk) begin
      cycle++;
      if (reset) begin
         m_state = 0;
         m_seq.delete();
         m_valid = 1'b1;
      end else if (m_valid) begin
         if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
            m_state = m_state;
         end else if (m_state == 13) begin
            m_state = 13;
         end else if (m_state == 0) begin
            m_state = 1;
         end else begin
            if (m_state == 1) m_seq = plan(OP, Funct);
            if (m_seq.size() > 0) m_state = m_seq.pop_front();
            else m_state = 0;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [28:0] act, exp;
      if (m_valid) begin
         act = {State, PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, Jal, JalReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, trap_obs};
         exp = exp_out(m_state, OP, mem_ready);
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL model_cmp cycle=%0d op=%h got=%h expected=%h", cycle, OP, act, exp);
         end
         if (RegWrite) rw_seen = 1'b1;
      end
   end

   // ---------------- directed helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic chks(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%s expected=%s", name, act, exp);
      end
   endtask

   logic [10:0] jal_snap;
   logic [6:0]  br_snap;
   logic [2:0]  alu6;
   logic [1:0]  jr_pcs;

   // Runs one instruction from FETCH back to FETCH, stalling the memory state 'stall' cycles.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int stall,
                            output string seq, output string rws, output int n);
      int st;
      st = stall; seq = ""; rws = ""; n = 0;
      OP = op; Funct = fn;
      for (int k = 0; k < 40; k++) begin
         if ((State == 4'd3 || State == 4'd5) && st > 0) begin mem_ready = 1'b0; st--; end
         else mem_ready = 1'b1;
         seq = {seq, $sformatf("%0d,", State)};
         if (RegWrite) rws = {rws, $sformatf("%0d,", State)};
         if (State == 4'd9)  jal_snap = {PCWrite, RegWrite, Jal, PCSource, JalReg};
         if (State == 4'd8)  br_snap  = {PCWriteCondEQ, PCWriteCondNE, ALUOp, PCSource};
         if (State == 4'd6)  alu6     = ALUOp;
         if (State == 4'd10) jr_pcs   = PCSource;
         n++;
         cyc();
         if (State == 4'd0) break;
      end
      if (State != 4'd0) begin
         checks++; errors++;
         $display("FAIL run_timeout op=%h got_state=%0d expected=0", op, State);
      end
   endtask

   initial begin : timeout
      #1000000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      string seq, rws;
      int n;
      logic [5:0] ops [12];
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h3F};

      reset = 1'b1; mem_ready = 1'b1; OP = 6'h00; Funct = 6'h20;
      cyc(); cyc();
      reset = 1'b0;
      chk("reset_state", int'(State), 0);
      chk("reset_fetch_enables", int'({MemRead, IRWrite, PCWrite}), 7);
      cyc();
      chk("reset_then_decode", int'(State), 1);
      for (int k = 0; k < 10 && State != 4'd0; k++) cyc();

      run_instr(6'h00, 6'h20, 0, seq, rws, n);
      chks("add_seq", seq, "0,1,6,7,"); chks("add_rw", rws, "7,"); chk("add_lat", n, 4);
      chk("add_aluop", int'(alu6), 7);

      run_instr(6'h23, 6'h00, 3, seq, rws, n);
      chks("lw_stall_seq", seq, "0,1,2,3,3,3,3,4,"); chks("lw_rw", rws, "4,");
      run_instr(6'h23, 6'h00, 0, seq, rws, n);
      chk("lw_lat", n, 5);

      run_instr(6'h2B, 6'h00, 0, seq, rws, n);
      chks("sw_seq", seq, "0,1,2,5,"); chks("sw_rw", rws, "");

      run_instr(6'h05, 6'h00, 0, seq, rws, n);
      chks("bne_seq", seq, "0,1,8,");
      chk("bne_ctrl", int'(br_snap), int'({1'b0, 1'b1, 3'b001, 2'b01}));
      run_instr(6'h04, 6'h00, 0, seq, rws, n);
      chk("beq_ctrl", int'(br_snap), int'({1'b1, 1'b0, 3'b001, 2'b01}));

      run_instr(6'h03, 6'h00, 0, seq, rws, n);
      chks("jal_seq", seq, "0,1,9,");
      chk("jal_ctrl", int'(jal_snap), int'({1'b1, 1'b1, 1'b1, 2'b10, 5'd31}));
      run_instr(6'h02, 6'h00, 0, seq, rws, n);
      chk("j_ctrl", int'(jal_snap), int'({1'b1, 1'b0, 1'b0, 2'b10, 5'd31}));

      run_instr(6'h00, 6'h08, 0, seq, rws, n);
      chks("jr_seq", seq, "0,1,10,"); chk("jr_pcsource", int'(jr_pcs), 3);

      run_instr(6'h0D, 6'h00, 0, seq, rws, n);
      chks("ori_seq", seq, "0,1,11,12,"); chks("ori_rw", rws, "12,");

`ifdef ILLEGAL_OP_TRAP_EN
      OP = 6'h3F; mem_ready = 1'b1;
      cyc(); cyc();
      for (int k = 0; k < 10; k++) begin
         chk("trap_state", int'(State), 13);
         chk("trap_flag", int'(trap_obs), 1);
         cyc();
      end
      reset = 1'b1; cyc(); reset = 1'b0;
      chk("trap_reset_state", int'(State), 0);
`else
      run_instr(6'h3F, 6'h00, 0, seq, rws, n);
      chks("illegal_nop_seq", seq, "0,1,");
`endif

      // Reset in the middle of a stalled LW.
      OP = 6'h23; mem_ready = 1'b1;
      for (int k = 0; k < 20 && State != 4'd3; k++) cyc();
      mem_ready = 1'b0;
      cyc();
      reset = 1'b1; rw_seen = 1'b0;
      cyc();
      reset = 1'b0;
      chk("midlw_reset_state", int'(State), 0);
      for (int k = 0; k < 5; k++) cyc();
      chk("midlw_no_regwrite", int'(rw_seen), 0);
      chk("midlw_still_fetch", int'(State), 0);

      // Randomized traffic, checked every cycle by the model comparison.
      for (int k = 0; k < 3000; k++) begin
         if (m_state == 0) begin
            OP = ops[$urandom_range(0, 11)];
            if (OP == 6'h3F) OP = 6'($urandom_range(0, 63));
            Funct = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         reset = (m_state == 13) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
         cyc();
      end
      reset = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle main control FSM for the MIPS core; replaces per-instruction combinational decode with a state sequence sharing one ALU and one unified memory.
- Sequences fetch, decode, execute, memory and writeback, and drives all datapath mux selects and write enables.
- Supported instructions: R-type, JR, ADDI, ANDI, ORI, LUI, LW, SW, BEQ, BNE, J, JAL.
- The memory handshake (mem_ready) stretches the memory-access states.

Parameters:
- RA_REG, 31, destination register index for JAL, exported on JalReg.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- OP  in  6  instruction opcode, IR[31:26].
- Funct  in  6  function field, IR[5:0].
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCondEQ  out  1  PC load if ALU Zero.
- PCWriteCondNE  out  1  PC load if ALU not Zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  writeback select: 1 = MDR.
- RegDst  out  1  destination select: 1 = rd.
- RegWrite  out  1  register file write.
- Jal  out  1  writeback select: PC, with destination JalReg.
- JalReg  out  5  constant RA_REG.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- PCSource  out  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = register A.
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 101 lui, 111 decode Funct.
- State  out  4  current state, for debug.

Behaviour:
- Defaults: every output not listed for a state is 0.
- Outputs are Moore, except PCWrite and IRWrite in FETCH, which are gated by mem_ready.
- Reset: on reset=1 at a clock edge, the state goes to FETCH and State=0. Reset mid-instruction aborts the instruction; no further RegWrite, MemWrite or PCWrite is asserted.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, JR=10, IMM_EXEC=11, IMM_WB=12, TRAP=13.
- FETCH:
  - Asserts MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=000 (precomputes the branch target).
  - Next state by OP:
    - 0x00 with Funct=0x08 -> JR; 0x00 otherwise -> EXECUTE.
    - 0x23 or 0x2B -> MEM_ADDR.
    - 0x04 or 0x05 -> BRANCH.
    - 0x02 or 0x03 -> JUMP.
    - 0x08, 0x0C, 0x0D, 0x0F -> IMM_EXEC.
    - Any other opcode -> see Optional Feature.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Goes to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: MemRead=1, IorD=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until mem_ready, then goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Goes to ALU_WB.
- ALU_WB: RegWrite=1, RegDst=1. Goes to FETCH.
- IMM_EXEC:
  - ALUSrcA=1, ALUSrcB=10.
  - ALUOp: ADDI=000, ANDI=010, ORI=011, LUI=101.
  - Goes to IMM_WB.
- IMM_WB: RegWrite=1, RegDst=0. Goes to FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01.
  - PCWriteCondEQ=1 for BEQ, PCWriteCondNE=1 for BNE.
  - Goes to FETCH.
- JUMP:
  - PCWrite=1, PCSource=10.
  - For JAL also RegWrite=1, Jal=1; the old PC+4 is written to RA_REG.
  - Goes to FETCH.
- JR: PCWrite=1, PCSource=11. Goes to FETCH.
- Latency with mem_ready constantly 1:
  - R-type, immediate ops and SW: 4 cycles.
  - LW: 5 cycles.
  - Branches, J, JAL and JR: 3 cycles.
  - Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- OP and Funct are sampled only in DECODE and later states; the IR is stable after FETCH.
- MemRead and MemWrite are never asserted in the same cycle.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP holds all enables at 0 and asserts extra output port Trap=1.
  - TRAP is left only by reset.
- Undefined:
  - An unknown opcode goes from DECODE to FETCH, a 2-cycle NOP.
  - No Trap port exists.

Test Plan:
- Reset: reset=1 for 2 cycles, then 0 with mem_ready=1 -> State=0; cycle 1 has MemRead=1, IRWrite=1, PCWrite=1; cycle 2 has State=1.
- R-type ADD (OP=0x00, Funct=0x20) -> states 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7; ALUOp=111 in state 6.
- LW (OP=0x23) with mem_ready=0 for 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0; MemtoReg=RegWrite=1 only in state 4.
- BNE (OP=0x05) -> states 0,1,8,0; PCWriteCondNE=1 and PCWriteCondEQ=0 in state 8; ALUOp=001.
- JAL (OP=0x03) -> in state 9: PCWrite=1, RegWrite=1, Jal=1, PCSource=10, JalReg=31. JR (OP=0x00, Funct=0x08) -> states 0,1,10 with PCSource=11.
- OP=0x3F, reset asserted in the middle of LW MEM_READ:
  - With ILLEGAL_OP_TRAP_EN: State=13 and Trap=1 held for 10 cycles.
  - Without it: return to FETCH after DECODE.
  - Mid-LW reset: State=0 next cycle and RegWrite never asserted.
